// File: rtl/regfile_bank.sv
// Integer register file with a destination-reservation scoreboard.
// The array is zeroed by a sweep after reset; x0 is hardwired to zero.
module regfile_bank #(
    parameter int XLEN  = 32,
    parameter int ADDRW = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            we,
    input  logic [ADDRW-1:0]                waddr,
    input  logic [XLEN-1:0]                 wdata,
    input  logic                            alloc,
    input  logic [ADDRW-1:0]                alloc_addr,
    output logic                            ready,
    output logic [0:XLEN*(2**ADDRW)-1]      regs_flat,
    output logic [(2**ADDRW)-1:0]           busy_flat
);

    localparam int NREG = 2 ** ADDRW;
    localparam logic [ADDRW-1:0] LAST_IDX = ADDRW'(NREG - 1);
    localparam logic [ADDRW-1:0] FIRST_IDX = ADDRW'(1);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDRW-1:0]  clr_idx_q, clr_idx_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [XLEN-1:0]   mem_q [NREG];

    logic run;
    logic wr_en;
    logic al_en;

    assign run   = (state_q == S_RUN);
    assign wr_en = run && we && (waddr != '0);
    assign al_en = run && alloc && (alloc_addr != '0);

    // Sweep sequencing: walk clr_idx through 1..NREG-1, then enter RUN.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            S_CLEAR: begin
                clr_idx_d = clr_idx_q + FIRST_IDX;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                clr_idx_d = clr_idx_q;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // Scoreboard next state: a write retires, an alloc reserves (alloc wins).
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[waddr] = 1'b0;
        end
        if (al_en) begin
            busy_d[alloc_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Control state and scoreboard registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= FIRST_IDX;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    // Storage array: no parallel reset, zeroed one entry per cycle in CLEAR.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!run) begin
                mem_q[clr_idx_q] <= '0;
            end else if (wr_en) begin
                mem_q[waddr] <= wdata;
            end
        end
    end

    // Outputs come only from registered state and are masked until ready.
    always_comb begin
        regs_flat = '0;
        for (int i = 1; i < NREG; i++) begin
            regs_flat[XLEN*i +: XLEN] = run ? mem_q[i] : '0;
        end
        busy_flat = run ? busy_q : '0;
        ready     = run;
    end

endmodule

// File: tb/tb_regfile_bank.sv
// Bench for regfile_bank: directed scenarios plus random traffic
// checked every cycle against a behavioural register-file model.
module tb_regfile_bank;

    localparam int XLEN  = 32;
    localparam int ADDRW = 5;
    localparam int NREG  = 32;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    we = 1'b0;
    logic [ADDRW-1:0]        waddr = '0;
    logic [XLEN-1:0]         wdata = '0;
    logic                    alloc = 1'b0;
    logic [ADDRW-1:0]        alloc_addr = '0;
    logic                    ready;
    logic [0:XLEN*NREG-1]    regs_flat;
    logic [NREG-1:0]         busy_flat;

    int checks = 0;
    int failures = 0;

    logic [XLEN-1:0] m_regs [NREG];
    logic [NREG-1:0] m_busy = '0;
    int              m_since = 0;

    regfile_bank #(.XLEN(XLEN), .ADDRW(ADDRW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .alloc      (alloc),
        .alloc_addr (alloc_addr),
        .ready      (ready),
        .regs_flat  (regs_flat),
        .busy_flat  (busy_flat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] fld(input int i);
        return regs_flat[XLEN*i +: XLEN];
    endfunction

    // Model: ready after NREG-1 edges out of reset, whole array zero then.
    task automatic model_edge();
        if (!rst_n) begin
            m_since = 0;
            m_busy  = '0;
        end else if (m_since < NREG - 1) begin
            m_since++;
            if (m_since == NREG - 1) begin
                for (int i = 0; i < NREG; i++) m_regs[i] = '0;
            end
        end else begin
            if (we && waddr != 0) begin
                m_regs[waddr] = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (alloc && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
    endtask

    task automatic check_all();
        logic rdy;
        rdy = (m_since == NREG - 1);
        check("ready", {31'b0, ready}, {31'b0, rdy});
        check("busy", busy_flat, rdy ? m_busy : '0);
        for (int i = 0; i < NREG; i++) begin
            check($sformatf("reg%0d", i), fld(i),
                  (rdy && i != 0) ? m_regs[i] : '0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        we = 1'b0;
        alloc = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;

        rst_n = 1'b0;
        tick();
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_busy", busy_flat, 32'd0);
        rst_n = 1'b1;

        for (int c = 1; c <= 31; c++) begin
            if (c == 10) begin
                we = 1'b1; waddr = 5'd3; wdata = 32'hAA;
                alloc = 1'b1; alloc_addr = 5'd3;
            end else begin
                idle();
            end
            tick();
            if (c == 30) check("ready_edge30", {31'b0, ready}, 32'd0);
        end
        idle();
        check("ready_edge31", {31'b0, ready}, 32'd1);
        check("clear_wr_ign", fld(3), 32'd0);
        check("clear_al_ign", {31'b0, busy_flat[3]}, 32'd0);

        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        idle();
        check("wr5", fld(5), 32'hDEADBEEF);
        check("wr5_other", fld(6), 32'd0);

        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        alloc = 1'b1; alloc_addr = 5'd0;
        tick();
        idle();
        check("x0_val", fld(0), 32'd0);
        check("x0_busy", {31'b0, busy_flat[0]}, 32'd0);

        alloc = 1'b1; alloc_addr = 5'd7;
        tick();
        idle();
        check("al7_busy", {31'b0, busy_flat[7]}, 32'd1);
        we = 1'b1; waddr = 5'd7; wdata = 32'h12;
        tick();
        idle();
        check("wr7_busy", {31'b0, busy_flat[7]}, 32'd0);
        check("wr7_val", fld(7), 32'h12);
        we = 1'b1; waddr = 5'd9; wdata = 32'h34;
        alloc = 1'b1; alloc_addr = 5'd9;
        tick();
        idle();
        check("both9_val", fld(9), 32'h34);
        check("both9_busy", {31'b0, busy_flat[9]}, 32'd1);

        we = 1'b1; waddr = 5'd4; wdata = 32'h55;
        alloc = 1'b1; alloc_addr = 5'd4;
        tick();
        idle();
        check("pre_rst4", fld(4), 32'h55);
        check("pre_rst_b4", {31'b0, busy_flat[4]}, 32'd1);
        rst_n = 1'b0;
        we = 1'b1; waddr = 5'd6; wdata = 32'h66;
        alloc = 1'b1; alloc_addr = 5'd6;
        tick();
        idle();
        rst_n = 1'b1;
        check("mid_rst_rdy", {31'b0, ready}, 32'd0);
        check("mid_rst_busy", busy_flat, 32'd0);
        repeat (30) tick();
        check("mid_rst_rdy30", {31'b0, ready}, 32'd0);
        tick();
        check("mid_rst_rdy31", {31'b0, ready}, 32'd1);
        check("mid_rst_r4", fld(4), 32'd0);
        check("mid_rst_r5", fld(5), 32'd0);

        repeat (15) tick();
        check("sweep_rdy", {31'b0, ready}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (31) tick();
        check("resweep_rdy", {31'b0, ready}, 32'd1);

        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            we = $urandom_range(0, 1);
            alloc = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 1) == 0) begin
                waddr = 5'($urandom_range(0, 3));
                alloc_addr = 5'($urandom_range(0, 3));
            end else begin
                waddr = 5'($urandom);
                alloc_addr = 5'($urandom);
            end
            wdata = $urandom;
            tick();
        end
        rst_n = 1'b1;
        idle();
        repeat (32) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
